// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared states and default geometry for the PE array controller.
// Holds the FSM state type and the constants derived from the default parameters.
package pe_array_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;
   localparam int DEF_L_RAM_SIZE = 4;
   localparam int DEF_L_NUM_PE = 2;
   localparam int N = 2 ** DEF_L_RAM_SIZE;
   localparam int NUM_PE = 2 ** DEF_L_NUM_PE;
   localparam int ADDR_W = DEF_L_RAM_SIZE + DEF_L_NUM_PE + 1;
   localparam int LOAD_CYCLES = (NUM_PE + 1) * N + 1;
endpackage

// File: rtl/pe_vbuf.sv
// pe_vbuf: single-port vector buffer, DATA_W x 2**AW, registered read (old data on write).
// Ports: aclk clock; we write enable; addr shared read/write address;
//        din write data; dout read data one cycle after addr.
module pe_vbuf #(
   parameter int DATA_W = 32,
   parameter int AW = 4
) (
   input  logic              aclk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] mem [2**AW];
   always_ff @(posedge aclk) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
   end
endmodule

// File: rtl/pe_array_con.sv
// pe_array_con: drives 2**L_NUM_PE MAC PEs to compute y = M*v from a shared source memory.
// Ports: aclk/aresetn clock and sync active-low reset; start/busy/done run control;
//        rdaddr/rddata source memory read (1-cycle latency); wr_en/wraddr/wrdata result write;
//        pe_clr/pe_we/pe_addr/pe_din PE clear and local RAM load; pe_ain/pe_valid element
//        broadcast; pe_dvalid/pe_dout per-PE completion and accumulator values.
module pe_array_con
   import pe_array_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int L_RAM_SIZE = DEF_L_RAM_SIZE,
   parameter int L_NUM_PE = DEF_L_NUM_PE,
   parameter int DONE_HOLD = 5
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic                                 start,
   output logic                                 busy,
   output logic                                 done,
   output logic [L_RAM_SIZE+L_NUM_PE:0]         rdaddr,
   input  logic [DATA_W-1:0]                    rddata,
   output logic                                 wr_en,
   output logic [L_NUM_PE-1:0]                  wraddr,
   output logic [DATA_W-1:0]                    wrdata,
   output logic                                 pe_clr,
   output logic [2**L_NUM_PE-1:0]               pe_we,
   output logic [L_RAM_SIZE-1:0]                pe_addr,
   output logic [DATA_W-1:0]                    pe_din,
   output logic [DATA_W-1:0]                    pe_ain,
   output logic                                 pe_valid,
   input  logic [2**L_NUM_PE-1:0]               pe_dvalid,
   input  logic [(2**L_NUM_PE)*DATA_W-1:0]      pe_dout
);
   localparam int N_EL = 2 ** L_RAM_SIZE;
   localparam int N_PE = 2 ** L_NUM_PE;
   localparam int AW = L_RAM_SIZE + L_NUM_PE + 1;
   localparam int LC = (N_PE + 1) * N_EL + 1;
   localparam int CW = (AW > $clog2(DONE_HOLD + 1)) ? AW : $clog2(DONE_HOLD + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [L_RAM_SIZE-1:0] el, el_n;
   logic [1:0] ph, ph_n;
   logic [N_PE-1:0] seen, seen_n, mark;
   logic [AW-1:0] ld_addr;
   logic ld_vld, ld_pe, wait_ph, last_el, vb_we;
   logic [L_NUM_PE:0] row, row_idx;
   logic [L_RAM_SIZE-1:0] vb_addr;
   logic [DATA_W-1:0] vb_dout;
   logic [DATA_W-1:0] result [N_PE];
   // CALC sub-phases: 0 read vbuf, 1 broadcast, 2 collect dvalids
   assign mark = seen | pe_dvalid;
   assign wait_ph = state == S_CALC && ph == 2'd2;
   assign last_el = &el;
   // ld_addr is the address issued last cycle, i.e. the one rddata belongs to
   assign row = ld_addr[AW-1:L_RAM_SIZE];
   assign row_idx = row - (L_NUM_PE + 1)'(1);
   assign ld_pe = state == S_LOAD && ld_vld && row != '0;
   assign vb_we = state == S_LOAD && ld_vld && row == '0;
   assign vb_addr = state == S_LOAD ? ld_addr[L_RAM_SIZE-1:0] : el;
   assign busy = state != S_IDLE;
   assign done = state == S_DONE && cnt == CW'(DONE_HOLD - 1);
   assign pe_clr = state == S_IDLE && start;
   assign rdaddr = (state == S_LOAD && cnt != CW'(LC - 1)) ? cnt[AW-1:0] : '0;
   assign pe_we = ld_pe ? N_PE'(1) << row_idx : '0;
   assign pe_addr = ld_pe ? ld_addr[L_RAM_SIZE-1:0] : state == S_CALC ? el : '0;
   assign pe_din = ld_pe ? rddata : '0;
   assign pe_valid = state == S_CALC && ph == 2'd1;
   assign pe_ain = pe_valid ? vb_dout : '0;
   assign wr_en = state == S_WRITE;
   assign wraddr = wr_en ? cnt[L_NUM_PE-1:0] : '0;
   assign wrdata = wr_en ? result[cnt[L_NUM_PE-1:0]] : '0;
   pe_vbuf #(.DATA_W(DATA_W), .AW(L_RAM_SIZE)) u_vbuf (
      .aclk(aclk), .we(vb_we), .addr(vb_addr), .din(rddata), .dout(vb_dout)
   );
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      el_n = el;
      ph_n = ph;
      seen_n = seen;
      case (state)
         S_IDLE: if (start) begin
            state_n = S_LOAD;
            cnt_n = '0;
         end
         S_LOAD: if (cnt == CW'(LC - 1)) begin
            state_n = S_CALC;
            cnt_n = '0;
            el_n = '0;
            ph_n = '0;
            seen_n = '0;
         end else cnt_n = cnt + CW'(1);
         S_CALC: if (ph != 2'd2) ph_n = ph + 2'd1;
         else if (&mark) begin
            seen_n = '0;
            ph_n = '0;
            el_n = last_el ? '0 : el + L_RAM_SIZE'(1);
            if (last_el) begin
               state_n = S_WRITE;
               cnt_n = '0;
            end
         end else seen_n = mark;
         S_WRITE: if (cnt == CW'(N_PE - 1)) begin
            state_n = S_DONE;
            cnt_n = '0;
         end else cnt_n = cnt + CW'(1);
         S_DONE: if (done) begin
            state_n = S_IDLE;
            cnt_n = '0;
         end else cnt_n = cnt + CW'(1);
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= S_IDLE;
         cnt <= '0;
         el <= '0;
         ph <= '0;
         seen <= '0;
         ld_addr <= '0;
         ld_vld <= 1'b0;
         for (int p = 0; p < N_PE; p++) result[p] <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         el <= el_n;
         ph <= ph_n;
         seen <= seen_n;
         ld_addr <= cnt[AW-1:0];
         ld_vld <= state == S_LOAD && cnt != CW'(LC - 1);
         // only the first dvalid of the last element carries the final sum
         if (wait_ph && last_el)
            for (int p = 0; p < N_PE; p++)
               if (pe_dvalid[p] && !seen[p]) result[p] <= pe_dout[p*DATA_W +: DATA_W];
      end
   end
endmodule

// File: tb/tb_pe_array_con.sv
// tb_pe_array_con: directed bench for pe_array_con with behavioural memory and MAC PEs.
module tb_pe_array_con;
   import pe_array_pkg::*;
   localparam int DW = 32;
   logic aclk = 1'b0, aresetn = 1'b0, start = 1'b0;
   logic busy, done, wr_en, pe_clr, pe_valid;
   logic [ADDR_W-1:0] rdaddr;
   logic [DW-1:0] rddata, wrdata, pe_din, pe_ain;
   logic [DEF_L_NUM_PE-1:0] wraddr;
   logic [NUM_PE-1:0] pe_we, pe_dvalid;
   logic [DEF_L_RAM_SIZE-1:0] pe_addr;
   logic [NUM_PE*DW-1:0] pe_dout;
   logic [DW-1:0] mem [2**ADDR_W];
   logic [DW-1:0] pram [NUM_PE][N];
   logic [DW-1:0] acc [NUM_PE];
   logic [15:0] sched [NUM_PE];
   int lat [NUM_PE];
   bit dup [NUM_PE];
   int total = 0, bad = 0;
   int cyc = 0, t0 = 0, first_we0, last_we, first_v, nval, order_bad, onehot_bad, nwr, done_n, clr_n;
   logic [NUM_PE-1:0] seen_tb;
   logic busy_q = 1'b0;
   logic [DW-1:0] res [NUM_PE];

   always #5 aclk = ~aclk;

   pe_array_con #(.DATA_W(DW)) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
      .rdaddr(rdaddr), .rddata(rddata), .wr_en(wr_en), .wraddr(wraddr), .wrdata(wrdata),
      .pe_clr(pe_clr), .pe_we(pe_we), .pe_addr(pe_addr), .pe_din(pe_din), .pe_ain(pe_ain),
      .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
   );

   always @(posedge aclk) rddata <= mem[rdaddr];

   // MAC PEs: dvalid after lat cycles, optionally repeated two cycles later
   always @(posedge aclk)
      for (int p = 0; p < NUM_PE; p++) begin
         if (pe_we[p]) pram[p][pe_addr] <= pe_din;
         if (!aresetn) begin
            acc[p] <= '0;
            sched[p] <= '0;
         end else begin
            if (pe_clr) acc[p] <= '0;
            else if (pe_valid) acc[p] <= acc[p] + pe_ain * pram[p][pe_addr];
            sched[p] <= pe_valid ? ((16'(1) << (lat[p] - 1)) | (dup[p] ? 16'(1) << (lat[p] + 1) : 16'(0))) : sched[p] >> 1;
         end
      end

   always_comb begin
      pe_dvalid = '0;
      pe_dout = '0;
      for (int p = 0; p < NUM_PE; p++) begin
         pe_dvalid[p] = sched[p][0];
         pe_dout[p*DW +: DW] = acc[p];
      end
   end

   always @(negedge aclk) begin
      cyc++;
      if (aresetn) begin
         if (busy && !busy_q) t0 = cyc;
         if (pe_we[0] && first_we0 < 0) first_we0 = cyc - t0;
         if (pe_we != 0) last_we = cyc - t0;
         if ((pe_we & (pe_we - 1'b1)) != 0) onehot_bad++;
         if (pe_valid) begin
            if (first_v < 0) first_v = cyc - t0;
            if (nval > 0 && seen_tb != '1) order_bad++;
            seen_tb = '0;
            nval++;
         end
         seen_tb |= pe_dvalid;
         if (wr_en) begin
            res[wraddr] = wrdata;
            nwr++;
         end
         done_n += int'(done);
         clr_n += int'(pe_clr);
      end
      busy_q = busy;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clr_stats();
      first_we0 = -1;
      last_we = -1;
      first_v = -1;
      nval = 0;
      order_bad = 0;
      onehot_bad = 0;
      nwr = 0;
      done_n = 0;
      clr_n = 0;
      seen_tb = '0;
      for (int p = 0; p < NUM_PE; p++) res[p] = '0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 3000) begin
         tick();
         n++;
      end
      chk("done_seen", 64'(done), 1);
      tick();
   endtask

   task automatic wait_nval(input int k);
      int n = 0;
      while (nval < k && n < 2000) begin
         tick();
         n++;
      end
      chk("reach_calc", 64'(nval >= k), 1);
   endtask

   task automatic do_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
   endtask

   task automatic set_pes(input int l0, l1, l2, l3, input bit d);
      lat = '{l0, l1, l2, l3};
      dup = '{d, d, d, 1'b0};
   endtask

   task automatic load_mem(input bit ident);
      for (int i = 0; i < N; i++) mem[i] = ident ? DW'(i) : DW'(1);
      for (int p = 0; p < NUM_PE; p++)
         for (int j = 0; j < N; j++)
            mem[(p + 1) * N + j] = ident ? DW'(j == p) : DW'(p + 1);
   endtask

   task automatic chk_res(input string tag, input bit ident);
      for (int p = 0; p < NUM_PE; p++)
         chk($sformatf("%s_res%0d", tag, p), 64'(res[p]), ident ? 64'(p) : 64'(N * (p + 1)));
      chk({tag, "_nwr"}, 64'(nwr), NUM_PE);
   endtask

   initial begin
      set_pes(3, 3, 3, 3, 1'b0);
      load_mem(1'b0);
      clr_stats();
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_rdaddr", 64'(rdaddr), 0);
      chk("rst_wr", {wr_en, wraddr, wrdata}, 0);
      chk("rst_pe", {pe_clr, pe_we, pe_addr, pe_din, pe_ain, pe_valid}, 0);
      aresetn = 1'b1;
      tick();
      clr_stats();
      do_run();
      chk_res("base", 1'b0);
      chk("base_done", 64'(done_n), 1);
      chk("base_clr", 64'(clr_n), 1);
      chk("first_we0", 64'(first_we0), N + 1);
      chk("last_we", 64'(last_we), LOAD_CYCLES - 1);
      chk("first_valid", 64'(first_v), LOAD_CYCLES + 1);
      chk("we_onehot", 64'(onehot_bad), 0);
      chk("base_nval", 64'(nval), N);
      chk("base_order", 64'(order_bad), 0);
      set_pes(1, 4, 2, 7, 1'b1);
      clr_stats();
      do_run();
      chk_res("skew", 1'b0);
      chk("skew_order", 64'(order_bad), 0);
      chk("skew_nval", 64'(nval), N);
      chk("skew_done", 64'(done_n), 1);
      set_pes(3, 3, 3, 3, 1'b0);
      clr_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_nval(2);
      start = 1'b1;
      #1;
      chk("calc_clr_ignored", 64'(pe_clr), 0);
      tick();
      chk("calc_busy", 64'(busy), 1);
      start = 1'b0;
      wait_done();
      repeat (20) tick();
      chk("restart_busy", 64'(busy), 0);
      chk("restart_done", 64'(done_n), 1);
      chk("restart_clr", 64'(clr_n), 1);
      chk_res("restart", 1'b0);
      clr_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_nval(3);
      aresetn = 1'b0;
      tick();
      chk("abort_busy", 64'(busy), 0);
      chk("abort_out", {wr_en, pe_valid, pe_we}, 0);
      aresetn = 1'b1;
      repeat (150) tick();
      chk("abort_nwr", 64'(nwr), 0);
      chk("abort_done", 64'(done_n), 0);
      clr_stats();
      do_run();
      chk_res("after_abort", 1'b0);
      load_mem(1'b1);
      for (int r = 0; r < 2; r++) begin
         clr_stats();
         do_run();
         chk_res($sformatf("b2b%0d", r), 1'b1);
         chk($sformatf("b2b%0d_clr", r), 64'(clr_n), 1);
         chk($sformatf("b2b%0d_done", r), 64'(done_n), 1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end
endmodule
